// File: rtl/div_unit.sv
// Iterative RV32M divider: radix-2 restoring division, one quotient bit per cycle,
// with divide-by-zero and signed-overflow results resolved in a single cycle.
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_addr,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      wb_addr
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_e          state_q, state_d;
   logic            sel_rem_q, sel_rem_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;
   logic [4:0]      rd_q, rd_d;
   logic [4:0]      wb_addr_q, wb_addr_d;
   logic [XLEN:0]   rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [5:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] result_q, result_d;

   // Operand preparation for an incoming request (op[0]=0 marks the signed ops).
   logic            op_signed, sign1, sign2, div_zero, sig_ovf;
   logic [XLEN-1:0] abs1, abs2, special_res;

   always_comb begin
      op_signed   = ~op[0];
      sign1       = op_signed & rs1_data[XLEN-1];
      sign2       = op_signed & rs2_data[XLEN-1];
      abs1        = sign1 ? -rs1_data : rs1_data;
      abs2        = sign2 ? -rs2_data : rs2_data;
      div_zero    = (rs2_data == '0);
      sig_ovf     = op_signed && (rs1_data == MIN_NEG) && (rs2_data == '1);
      special_res = div_zero ? (op[1] ? rs1_data : '1)
                             : (op[1] ? '0 : MIN_NEG);
   end

   // One restoring step; the extra top bit of the difference is the borrow.
   logic [XLEN+1:0] diff;
   logic            fits;
   logic [XLEN:0]   step_rem;
   logic [XLEN-1:0] step_quo, quo_fix, rem_fix;

   always_comb begin
      diff     = {rem_q, quo_q[XLEN-1]} - {2'b00, dvs_q};
      fits     = ~diff[XLEN+1];
      step_rem = fits ? diff[XLEN:0] : {rem_q[XLEN-1:0], quo_q[XLEN-1]};
      step_quo = {quo_q[XLEN-2:0], fits};
      quo_fix  = neg_quo_q ? -step_quo : step_quo;
      rem_fix  = neg_rem_q ? -step_rem[XLEN-1:0] : step_rem[XLEN-1:0];
   end

   always_comb begin
      // NOTE: every _d takes its hold value first so no path through the case leaves a latch.
      state_d   = state_q;
      sel_rem_d = sel_rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      rd_d      = rd_q;
      wb_addr_d = wb_addr_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: if (start) begin
               sel_rem_d = op[1];
               neg_quo_d = sign1 ^ sign2;
               neg_rem_d = sign1;
               rd_d      = rd_addr;
               rem_d     = '0;
               quo_d     = abs1;
               dvs_d     = abs2;
               cnt_d     = '0;
               if (div_zero || sig_ovf) begin
                  state_d   = DONE;
                  result_d  = special_res;
                  wb_addr_d = rd_addr;
               end else begin
                  state_d = CALC;
               end
            end
            CALC: begin
               rem_d = step_rem;
               quo_d = step_quo;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'(XLEN - 1)) begin
                  state_d   = DONE;
                  result_d  = sel_rem_q ? rem_fix : quo_fix;
                  wb_addr_d = rd_q;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: datapath registers are reset too, because result/wb_addr must read 0 after reset.
      if (!rst_n) begin
         state_q   <= IDLE;
         sel_rem_q <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         rd_q      <= '0;
         wb_addr_q <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         sel_rem_q <= sel_rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         rd_q      <= rd_d;
         wb_addr_q <= wb_addr_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign result  = result_q;
   assign wb_addr = wb_addr_q;

endmodule
